// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle ALU control sequencer: IDLE -> DECODE -> EXEC (N cycles) -> WB -> IDLE.
// Accept-to-IDLE takes 3+N cycles (N=MUL_CYCLES for MUL, else 1); instr_ready only in IDLE.
module alu_ctrl_fsm #(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [3:0]  alu_control,
  output logic        alu_src_b,
  output logic [31:0] imm_ext,
  input  logic        zero,
  output logic [4:0]  rf_raddr_a,
  output logic [4:0]  rf_raddr_b,
  output logic [4:0]  rf_waddr,
  output logic        rf_we,
  output logic        branch_taken,
  output logic [15:0] branch_offset,
  output logic        busy,
  output logic        illegal
);

  localparam logic [5:0] OP_MUL  = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h09;
  localparam logic [5:0] OP_BNE  = 6'h0A;
  localparam logic [5:0] OP_SEQ  = 6'h0B;
  localparam logic [3:0] ALU_UNDEF = 4'b1111;
  localparam logic [3:0] MUL_DWELL = 4'(MUL_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_e;

  function automatic logic [3:0] alu_code(input logic [5:0] op);
    logic [3:0] code;
    code = ALU_UNDEF;
    case (op)
      6'h00:   code = 4'b0000;
      6'h01:   code = 4'b0001;
      6'h02:   code = 4'b0010;
      6'h03:   code = 4'b0011;
      6'h04:   code = 4'b0100;
      6'h05:   code = 4'b0101;
      6'h06:   code = 4'b0110;
      OP_MUL:  code = 4'b0111;
      OP_ADDI: code = 4'b0000;
      OP_BEQ:  code = 4'b0001;
      OP_BNE:  code = 4'b0001;
      OP_SEQ:  code = 4'b1000;
      default: code = ALU_UNDEF;
    endcase
    return code;
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    return op <= OP_SEQ;
  endfunction

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [5:0]  op_q;
  logic [3:0]  alu_control_q;
  logic        alu_src_b_q;
  logic [31:0] imm_ext_q;
  logic [4:0]  rf_raddr_a_q;
  logic [4:0]  rf_raddr_b_q;
  logic [4:0]  rf_waddr_q;
  logic        rf_we_q;
  logic        branch_taken_q;
  logic [15:0] branch_offset_q;
  logic        illegal_q;

  // Decode of the offered instruction, captured straight into the output registers
  // at the accept edge so the DECODE cycle already presents the controls.
  logic [5:0]  op_d;
  logic [3:0]  alu_control_d;
  logic        alu_src_b_d;
  logic [31:0] imm_ext_d;
  logic        is_branch_q;

  assign op_d          = instr[31:26];
  assign alu_control_d = alu_code(op_d);
  assign alu_src_b_d   = (op_d == OP_ADDI);
  assign imm_ext_d     = {{16{instr[15]}}, instr[15:0]};
  assign is_branch_q   = (op_q == OP_BEQ) || (op_q == OP_BNE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= 4'd0;
      op_q            <= 6'd0;
      alu_control_q   <= ALU_UNDEF;
      alu_src_b_q     <= 1'b0;
      imm_ext_q       <= 32'd0;
      rf_raddr_a_q    <= 5'd0;
      rf_raddr_b_q    <= 5'd0;
      rf_waddr_q      <= 5'd0;
      rf_we_q         <= 1'b0;
      branch_taken_q  <= 1'b0;
      branch_offset_q <= 16'd0;
      illegal_q       <= 1'b0;
    end else begin
      rf_we_q        <= 1'b0;
      branch_taken_q <= 1'b0;
      illegal_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            op_q          <= op_d;
            alu_control_q <= alu_control_d;
            alu_src_b_q   <= alu_src_b_d;
            imm_ext_q     <= imm_ext_d;
            rf_raddr_a_q  <= instr[20:16];
            rf_raddr_b_q  <= instr[15:11];
            rf_waddr_q    <= instr[25:21];
            illegal_q     <= !op_legal(op_d);
            state_q       <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!op_legal(op_q)) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= (op_q == OP_MUL) ? MUL_DWELL : 4'd1;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          cnt_q <= cnt_q - 4'd1;
          // Zero is only meaningful at the final EXEC edge; earlier dwell cycles ignore it.
          if (cnt_q == 4'd1) begin
            state_q        <= S_WB;
            rf_we_q        <= !is_branch_q && (rf_waddr_q != 5'd0);
            branch_taken_q <= (op_q == OP_BEQ) ? zero :
                              (op_q == OP_BNE) ? !zero : 1'b0;
            if (is_branch_q) branch_offset_q <= imm_ext_q[15:0];
          end
        end
        S_WB: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_ready   = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign alu_control   = alu_control_q;
  assign alu_src_b     = alu_src_b_q;
  assign imm_ext       = imm_ext_q;
  assign rf_raddr_a    = rf_raddr_a_q;
  assign rf_raddr_b    = rf_raddr_b_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_we         = rf_we_q;
  assign branch_taken  = branch_taken_q;
  assign branch_offset = branch_offset_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Self-checking bench for alu_ctrl_fsm: directed scenarios plus a randomized back-to-back stream.
module tb_alu_ctrl_fsm;
  localparam int MULN = 3;
  localparam int NRAND = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        zero = 1'b0;
  logic        instr_ready, alu_src_b, rf_we, branch_taken, busy, illegal;
  logic [3:0]  alu_control;
  logic [31:0] imm_ext;
  logic [4:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] branch_offset;

  int checks = 0;
  int errors = 0;

  alu_ctrl_fsm #(.MUL_CYCLES(MULN)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_control(alu_control), .alu_src_b(alu_src_b), .imm_ext(imm_ext),
    .zero(zero), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Per-cycle trace of one instruction; index c = c-th cycle after the accept edge.
  logic        r_ready [0:15];
  logic        r_we    [0:15];
  logic        r_bt    [0:15];
  logic        r_ill   [0:15];
  logic        r_srcb  [0:15];
  logic [3:0]  r_alu   [0:15];
  logic [4:0]  r_ra    [0:15];
  logic [4:0]  r_rb    [0:15];
  logic [4:0]  r_wa    [0:15];
  logic [31:0] r_imm   [0:15];
  logic [15:0] r_off   [0:15];

  // Reference model of the opcode table.
  function automatic logic ref_legal(input logic [5:0] op);
    return op < 6'd12;
  endfunction
  function automatic logic [3:0] ref_alu(input logic [5:0] op);
    if (op < 6'd8) return op[3:0];
    if (op == 6'd8) return 4'd0;
    if (op == 6'd11) return 4'd8;
    return 4'd1;
  endfunction
  function automatic int ref_dwell(input logic [5:0] op);
    return (op == 6'd7) ? MULN : 1;
  endfunction
  function automatic logic ref_writes(input logic [31:0] ins);
    return ref_legal(ins[31:26]) && ins[31:26] != 6'd9 && ins[31:26] != 6'd10 && ins[25:21] != 5'd0;
  endfunction
  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(12, 63)) : 6'($urandom_range(0, 11));
    return {op, 26'($urandom)};
  endfunction

  // Offer one instruction from IDLE and record 15 cycles; zmask[c] drives zero during cycle c.
  task automatic run(input logic [31:0] ins, input logic [15:0] zmask);
    instr = ins; instr_valid = 1'b1; zero = zmask[0];
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = $urandom;
    for (int c = 1; c < 16; c++) begin
      r_ready[c] = instr_ready; r_we[c] = rf_we; r_bt[c] = branch_taken; r_ill[c] = illegal;
      r_srcb[c] = alu_src_b; r_alu[c] = alu_control; r_ra[c] = rf_raddr_a; r_rb[c] = rf_raddr_b;
      r_wa[c] = rf_waddr; r_imm[c] = imm_ext; r_off[c] = branch_offset;
      zero = zmask[c];
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({instr_ready, busy, alu_control, alu_src_b} !== {1'b1, 1'b0, 4'hF, 1'b0}) begin
      errors++; $display("FAIL reset_ctl got %b exp %b", {instr_ready, busy, alu_control, alu_src_b}, 7'b1011110);
    end
    checks++;
    if ({imm_ext, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, branch_taken, branch_offset, illegal} !== 67'd0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {imm_ext, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, branch_taken, branch_offset, illegal});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    run({6'h00, 5'd3, 5'd1, 5'd2, 11'd0}, 16'h0);
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (r_we[c] !== (c == 3) || r_ready[c] !== (c >= 4)) begin
        errors++; $display("FAIL add_timing c=%0d got we=%b rdy=%b exp we=%b rdy=%b", c, r_we[c], r_ready[c], c == 3, c >= 4);
      end
    end
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if ({r_alu[c], r_srcb[c], r_ra[c], r_rb[c], r_wa[c]} !== {4'd0, 1'b0, 5'd1, 5'd2, 5'd3}) begin
        errors++; $display("FAIL add_ctl c=%0d got %h exp %h", c, {r_alu[c], r_srcb[c], r_ra[c], r_rb[c], r_wa[c]}, {4'd0, 1'b0, 5'd1, 5'd2, 5'd3});
      end
    end
  endtask

  task automatic test_addi();
    run({6'h08, 5'd7, 5'd4, 16'hFFFE}, 16'h0);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if ({r_imm[c], r_srcb[c], r_alu[c]} !== {32'hFFFFFFFE, 1'b1, 4'd0}) begin
        errors++; $display("FAIL addi_ctl c=%0d got %h exp %h", c, {r_imm[c], r_srcb[c], r_alu[c]}, {32'hFFFFFFFE, 1'b1, 4'd0});
      end
    end
    checks++;
    if ({r_we[3], r_wa[3]} !== {1'b1, 5'd7}) begin
      errors++; $display("FAIL addi_wb got %b exp %b", {r_we[3], r_wa[3]}, {1'b1, 5'd7});
    end
  endtask

  task automatic test_mul();
    // zero toggles during early dwell, 0 at the final EXEC cycle (c = 1+MULN)
    run({6'h07, 5'd9, 5'd5, 5'd6, 11'd0}, 16'h000A);
    for (int c = 1; c <= 2 + MULN + 2; c++) begin
      checks++;
      if (r_we[c] !== (c == 2 + MULN) || r_bt[c] !== 1'b0 || r_ready[c] !== (c >= 3 + MULN)) begin
        errors++; $display("FAIL mul_timing c=%0d got we=%b bt=%b rdy=%b exp we=%b", c, r_we[c], r_bt[c], r_ready[c], c == 2 + MULN);
      end
      if (c <= 2 + MULN) begin
        checks++;
        if (r_alu[c] !== 4'd7) begin
          errors++; $display("FAIL mul_alu c=%0d got %h exp 7", c, r_alu[c]);
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [5:0] op;
    logic [15:0] zm, imm;
    logic exp;
    for (int t = 0; t < 8; t++) begin
      op = (t == 0) ? 6'h09 : (t == 1) ? 6'h0A : 6'($urandom_range(9, 10));
      zm = (t < 2) ? 16'h0004 : 16'($urandom);
      imm = 16'($urandom);
      exp = (op == 6'h09) ? zm[2] : !zm[2];
      run({op, 5'($urandom_range(1, 31)), 5'd2, imm}, zm);
      for (int c = 1; c <= 5; c++) begin
        checks++;
        if (r_bt[c] !== (c == 3 && exp) || r_we[c] !== 1'b0) begin
          errors++; $display("FAIL branch t=%0d c=%0d got bt=%b we=%b exp bt=%b", t, c, r_bt[c], r_we[c], c == 3 && exp);
        end
      end
      if (exp) begin
        checks++;
        if (r_off[3] !== imm) begin
          errors++; $display("FAIL branch_off got %h exp %h", r_off[3], imm);
        end
      end
    end
  endtask

  task automatic test_illegal();
    run({6'h3F, 5'd4, 5'd1, 5'd2, 11'd0}, 16'h0);
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (r_ill[c] !== (c == 1) || r_we[c] !== 1'b0 || r_ready[c] !== (c >= 2)) begin
        errors++; $display("FAIL illegal c=%0d got ill=%b we=%b rdy=%b exp ill=%b rdy=%b", c, r_ill[c], r_we[c], r_ready[c], c == 1, c >= 2);
      end
    end
  endtask

  task automatic test_rd0();
    run({6'h00, 5'd0, 5'd1, 5'd2, 11'd0}, 16'h0);
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (r_we[c] !== 1'b0 || r_ready[c] !== (c >= 4)) begin
        errors++; $display("FAIL rd0 c=%0d got we=%b rdy=%b exp we=0 rdy=%b", c, r_we[c], r_ready[c], c >= 4);
      end
    end
  endtask

  task automatic test_reset_mid();
    instr = {6'h00, 5'd5, 5'd1, 5'd2, 11'd0}; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({instr_ready, busy, alu_control, rf_we, branch_taken, illegal, rf_waddr, imm_ext} !== {1'b1, 1'b0, 4'hF, 3'b000, 5'd0, 32'd0}) begin
      errors++; $display("FAIL reset_mid got %h", {instr_ready, busy, alu_control, rf_we, branch_taken, illegal, rf_waddr, imm_ext});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (rf_we !== 1'b0 || branch_taken !== 1'b0 || instr_ready !== 1'b1) begin
        errors++; $display("FAIL reset_mid_after c=%0d got we=%b bt=%b rdy=%b", c, rf_we, branch_taken, instr_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int c, next_idle, dec_c, wb_c, n_acc;
    logic zh [0:1023];
    logic [31:0] cur;
    logic swap, done, exp_we, exp_bt, exp_ill;
    n_acc = 0; next_idle = 0; dec_c = -1; wb_c = -1; swap = 1'b0; done = 1'b0; cur = 32'd0;
    instr = rand_instr(); instr_valid = 1'b1;
    c = 0;
    while (!done) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (swap) begin
        if (n_acc == NRAND) instr_valid = 1'b0; else instr = rand_instr();
        swap = 1'b0;
      end
      exp_we = (c == wb_c) && ref_writes(cur);
      exp_bt = (c == wb_c) && ((cur[31:26] == 6'h09) ? zh[c-1] : (cur[31:26] == 6'h0A) ? !zh[c-1] : 1'b0);
      exp_ill = (c == dec_c) && !ref_legal(cur[31:26]);
      checks++;
      if ({rf_we, branch_taken, illegal} !== {exp_we, exp_bt, exp_ill}) begin
        errors++; $display("FAIL b2b_pulse c=%0d op=%h got %b exp %b", c, cur[31:26], {rf_we, branch_taken, illegal}, {exp_we, exp_bt, exp_ill});
      end
      if (exp_we || exp_bt) begin
        checks++;
        if ((exp_we && rf_waddr !== cur[25:21]) || (exp_bt && branch_offset !== cur[15:0])) begin
          errors++; $display("FAIL b2b_wb c=%0d got wa=%0d off=%h exp wa=%0d off=%h", c, rf_waddr, branch_offset, cur[25:21], cur[15:0]);
        end
      end
      if (c == dec_c && ref_legal(cur[31:26])) begin
        checks++;
        if ({alu_control, alu_src_b, rf_raddr_a, rf_raddr_b} !== {ref_alu(cur[31:26]), cur[31:26] == 6'h08, cur[20:16], cur[15:11]}) begin
          errors++; $display("FAIL b2b_decode c=%0d op=%h got %h", c, cur[31:26], {alu_control, alu_src_b, rf_raddr_a, rf_raddr_b});
        end
      end
      checks++;
      if (instr_ready !== (c >= next_idle) || busy !== (c < next_idle)) begin
        errors++; $display("FAIL b2b_ready c=%0d got rdy=%b busy=%b exp rdy=%b", c, instr_ready, busy, c >= next_idle);
      end
      if (c >= next_idle && instr_valid) begin
        cur = instr; n_acc++; swap = 1'b1; dec_c = c + 1;
        if (ref_legal(cur[31:26])) begin
          wb_c = c + 2 + ref_dwell(cur[31:26]); next_idle = wb_c + 1;
        end else begin
          wb_c = -1; next_idle = c + 2;
        end
      end
      zero = 1'($urandom_range(0, 1));
      zh[c] = zero;
      c++;
      if ((!instr_valid && c > next_idle + 2) || c >= 1000) done = 1'b1;
    end
    checks++;
    if (n_acc !== NRAND) begin
      errors++; $display("FAIL b2b_count got %0d exp %0d", n_acc, NRAND);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_mul();
    test_branch();
    test_illegal();
    test_rd0();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_fsm.md
# alu_ctrl_fsm

Multi-cycle control sequencer that drives the ALU's control-code interface. It accepts one 32-bit instruction at a time over a valid/ready handshake and decodes it. It then sequences DECODE, EXEC and WB states, driving the ALU control code, operand select and register-file addresses. It samples the ALU Zero flag to resolve branches and asserts the register-file write enable in writeback.

## Interface
- MUL_CYCLES, 3: EXEC dwell, in cycles, for MUL (multicycle multiplier path); legal range 1..15.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  an instruction is offered on instr.
- instr_ready  out  1  block can accept an instruction; high only in IDLE.
- instr  in  32  fields:
  - opcode[31:26], rd[25:21], rs[20:16], rt[15:11]
  - imm[15:0], overlapping rt.
- alu_control  out  4  ALU operation code.
- alu_src_b  out  1  ALU B operand select: 0 = register rt, 1 = imm_ext.
- imm_ext  out  32  imm sign-extended to 32 bits.
- zero  in  1  ALU Zero flag, combinational from the ALU.
- rf_raddr_a  out  5  register-file read address A (rs).
- rf_raddr_b  out  5  register-file read address B (rt).
- rf_waddr  out  5  register-file write address (rd).
- rf_we  out  1  register-file write enable; single-cycle pulse.
- branch_taken  out  1  single-cycle pulse: branch condition met.
- branch_offset  out  16  imm of the current branch, valid with branch_taken.
- busy  out  1  high in any state other than IDLE.
- illegal  out  1  single-cycle pulse: undefined opcode rejected.

## Operation
Opcode to ALU code mapping:
- 00 ADD→0000, 01 SUB→0001, 02 AND→0010, 03 OR→0011, 04 XOR→0100
- 05 SLL→0101, 06 SRL→0110, 07 MUL→0111
- 08 ADDI→0000 with alu_src_b=1
- 09 BEQ→0001, 0A BNE→0001
- 0B SEQ→1000
- Every other opcode is illegal.

States:
- IDLE: instr_ready=1. On instr_valid&instr_ready, register instr, go to DECODE.
- DECODE:
  - Drive rf_raddr_a/b, imm_ext, alu_src_b and alu_control from the registered instr.
  - Illegal opcode: pulse illegal, go to IDLE with no write.
  - Otherwise load the dwell counter (MUL_CYCLES for MUL, else 1) and go to EXEC.
- EXEC:
  - alu_control, alu_src_b and addresses are held stable; decrement the counter.
  - On the last EXEC cycle (counter==1), register zero into zero_q and go to WB.
- WB:
  - ALU ops and ADDI: rf_we=1 for one cycle, except rf_we=0 when rd==0 (r0 is read-only).
  - BEQ: branch_taken=zero_q. BNE: branch_taken=!zero_q. Branches never assert rf_we.
  - Go to IDLE.

Other rules:
- alu_control, alu_src_b, rf_* addresses and imm_ext are registered. They hold their values from DECODE through WB.
- In IDLE they retain the last instruction's values, except that rf_we, branch_taken and illegal are 0.
- instr_valid is ignored while busy. There is no queueing; the source must hold its instruction until accepted.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, instr_ready=1, busy=0.
  - alu_control=4'b1111 (undefined code; the ALU outputs 0).
  - alu_src_b=0, imm_ext=0, all rf addresses=0, rf_we=0.
  - branch_taken=0, branch_offset=0, illegal=0.
- Accept at edge T. Then DECODE in cycle T+1, EXEC in T+2..T+1+N, WB in T+2+N, IDLE in T+3+N.
  - N=1 for non-MUL, N=MUL_CYCLES for MUL.
- Throughput: one instruction per 4 cycles for non-MUL ops.
- rf_we/branch_taken assert only in WB. illegal asserts only in the DECODE cycle.
- Back-to-back: instr_ready rises in the cycle after WB. A held instr_valid is accepted at that cycle's edge.
- zero is sampled at the final EXEC edge only. Earlier zero glitches during MUL dwell have no effect.
- rst_n low mid-instruction: return to IDLE at once with no rf_we or branch_taken pulse. The in-flight instruction is discarded.
- rst_n deassertion is synchronised externally. The first acceptance can occur at the first edge with rst_n high.

## Test plan
- Reset: assert rst_n=0 mid-EXEC of an ADD → all outputs at their reset values within the same cycle; no rf_we pulse ever appears.
- ADD, rd=3, rs=1, rt=2, accepted at T:
  - alu_control=0000, alu_src_b=0, rf_raddr_a=1, rf_raddr_b=2 from T+1.
  - rf_we=1 with rf_waddr=3 only in T+3; instr_ready=1 at T+4.
- ADDI with imm=16'hFFFE → imm_ext=32'hFFFFFFFE, alu_src_b=1, alu_control=0000. MUL with MUL_CYCLES=3 → EXEC lasts 3 cycles; rf_we at T+5.
- BEQ with zero=1 at the final EXEC edge → branch_taken pulse with branch_offset=imm, rf_we=0.
  - BNE with zero=1 → no pulse.
  - MUL with zero toggling early and 0 at the final edge → result unaffected.
- Opcode 6'h3F → illegal pulse in T+1, no rf_we, instr_ready=1 at T+2. ADD with rd=0 → full sequence, rf_we stays 0.
- instr_valid held high continuously with varied opcodes → exactly one acceptance per instruction; none while busy=1; every WB pulse matches the expected op.
